// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeds a
// START/DATA/STOP serializer running at CLK_HZ/BAUD clocks per bit.
// Back-to-back bytes leave the line with no idle gap between frames.
module uart_tx_fifo #(
  parameter int CLK_HZ = 40000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 8
) (
  input  logic                   hwclk,
  input  logic                   reset,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_d;
  logic          pop;
  logic          push;
  logic          baud_last;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign tx_ready   = !reset && (fifo_count != FULL_COUNT);
  assign push       = tx_valid && tx_ready;
  assign busy       = (state_q != ST_IDLE);
  assign baud_last  = (baud_q == BAUD_LAST);

  // FIFO storage; an entry is only written on an accepted push, so it needs no reset
  always_ff @(posedge hwclk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop keeps the count steady
  always_ff @(posedge hwclk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Serializer state, counters and the registered line output
  always_ff @(posedge hwclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
    end
  end

  // Next-state logic; tx follows the current state so the line lags the FSM by one clock
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (fifo_count != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            bit_d   = '0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at 4 clocks per bit and a 4-deep FIFO.
// Accepted bytes are queued as expectations; a line monitor decodes
// each 40-cycle frame and compares it with the head of the queue.
module tb_uart_tx_fifo;

  logic       hwclk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] exp_q [$];
  int         start_times [$];

  int         mon_pos = -1;
  logic       prev_tx = 1'b1;
  logic [39:0] frame;
  logic [7:0] got_byte;
  logic       shape_ok;

  uart_tx_fifo #(
    .CLK_HZ(16),
    .BAUD(4),
    .DEPTH(4)
  ) dut (
    .hwclk(hwclk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx(tx),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  // Free-running clock, 10 time units per cycle
  always #5 hwclk = ~hwclk;

  // Edge counter: after rising edge n, cyc holds n
  always @(posedge hwclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Resumes 1 time unit after rising edge n (returns at once if already past it)
  task automatic toEdge(input int n);
    while (cyc < n) begin
      @(posedge hwclk);
      #1;
    end
  endtask

  // Offer one byte, hold it until accepted; acc_edge is the accepting edge
  task automatic applyStimulus(input logic [7:0] d, output int acc_edge);
    tx_data  = d;
    tx_valid = 1'b1;
    acc_edge = -1;
    for (int w = 0; w < 200; w++) begin
      @(negedge hwclk);
      if (tx_ready) begin
        acc_edge = cyc + 1;
        exp_q.push_back(d);
        @(posedge hwclk);
        #1;
        tx_valid = 1'b0;
        return;
      end
    end
    tx_valid = 1'b0;
    checkOutput("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_pos >= 0 || busy) && n < budget) begin
      @(posedge hwclk);
      #1;
      n++;
    end
    checkOutput("drain_done", {31'd0, n < budget}, 32'd1);
  endtask

  task automatic checkSpacing(input string name, input int base, input int nframes);
    checkOutput({name, "_frames"}, start_times.size() - base, nframes);
    for (int i = base + 1; i < start_times.size(); i++) begin
      checkOutput({name, "_spacing"}, start_times[i] - start_times[i-1], 32'd40);
    end
  endtask

  // Line monitor: captures 40 samples per frame, checks shape and scores the byte
  always @(negedge hwclk) begin
    if (reset) begin
      mon_pos = -1;
    end else if (mon_pos < 0) begin
      if (prev_tx && !tx) begin
        start_times.push_back(cyc);
        frame[0] = tx;
        mon_pos  = 1;
      end
    end else begin
      frame[mon_pos] = tx;
      mon_pos++;
      if (mon_pos == 40) begin
        mon_pos  = -1;
        shape_ok = 1'b1;
        for (int i = 0; i < 4; i++) if (frame[i] !== 1'b0) shape_ok = 1'b0;
        for (int i = 36; i < 40; i++) if (frame[i] !== 1'b1) shape_ok = 1'b0;
        for (int b = 0; b < 8; b++) begin
          got_byte[b] = frame[4 + 4*b];
          for (int j = 1; j < 4; j++) if (frame[4 + 4*b + j] !== got_byte[b]) shape_ok = 1'b0;
        end
        checkOutput("frame_shape", {31'd0, shape_ok}, 32'd1);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_frame", {24'd0, got_byte}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("frame_byte", {24'd0, got_byte}, {24'd0, exp_q.pop_front()});
        end
      end
    end
    prev_tx = tx;
  end

  // Hard stop if something stalls beyond all test budgets
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int k, a1, a5, a6, j, m, tmp, base, lows;

    // Reset idle
    toEdge(3);
    checkOutput("rst_tx", {31'd0, tx}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("rst_ready", {31'd0, tx_ready}, 32'd0);
    reset = 1'b0;
    @(negedge hwclk);
    checkOutput("post_rst_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("post_rst_tx", {31'd0, tx}, 32'd1);
    checkOutput("post_rst_count", {29'd0, fifo_count}, 32'd0);
    toEdge(cyc + 2);

    // Single byte 0xA5
    base = start_times.size();
    applyStimulus(8'hA5, k);
    toEdge(k + 40);
    checkOutput("a5_busy_last", {31'd0, busy}, 32'd1);
    checkOutput("a5_start_latency", start_times[base] - k, 32'd2);
    toEdge(k + 41);
    checkOutput("a5_busy_end", {31'd0, busy}, 32'd0);
    drain(100);

    // Fill and overflow
    base = start_times.size();
    applyStimulus(8'h01, a1);
    applyStimulus(8'h02, tmp);
    applyStimulus(8'h03, tmp);
    applyStimulus(8'h04, tmp);
    applyStimulus(8'h05, a5);
    checkOutput("fill_acc5", a5 - a1, 32'd4);
    checkOutput("fill_ready", {31'd0, tx_ready}, 32'd0);
    checkOutput("fill_count", {29'd0, fifo_count}, 32'd4);
    applyStimulus(8'h06, a6);
    checkOutput("fill_acc6", a6 - a1, 32'd42);
    drain(400);
    checkSpacing("fill", base, 6);

    // Simultaneous push/pop on the STOP->START pop edge
    applyStimulus(8'h5A, j);
    applyStimulus(8'hC3, tmp);
    applyStimulus(8'h81, tmp);
    toEdge(j + 40);
    checkOutput("pp_count_before", {29'd0, fifo_count}, 32'd2);
    applyStimulus(8'h7E, tmp);
    checkOutput("pp_acc_edge", tmp - j, 32'd41);
    checkOutput("pp_count_after", {29'd0, fifo_count}, 32'd2);
    drain(300);

    // Reset mid-frame during DATA bit 3 of 0x3C
    applyStimulus(8'h3C, m);
    applyStimulus(8'h11, tmp);
    applyStimulus(8'h22, tmp);
    toEdge(m + 10);
    checkOutput("mid_bit1", {31'd0, tx}, 32'd0);
    checkOutput("mid_count", {29'd0, fifo_count}, 32'd2);
    toEdge(m + 18);
    checkOutput("mid_bit3", {31'd0, tx}, 32'd1);
    reset = 1'b1;
    toEdge(m + 19);
    exp_q.delete();
    checkOutput("mid_rst_tx", {31'd0, tx}, 32'd1);
    checkOutput("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_ready", {31'd0, tx_ready}, 32'd0);
    toEdge(m + 20);
    reset = 1'b0;
    base = start_times.size();
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge hwclk);
      if (tx !== 1'b1) lows++;
    end
    checkOutput("mid_idle_lows", lows, 32'd0);
    checkOutput("mid_idle_frames", start_times.size() - base, 32'd0);
    checkOutput("mid_idle_busy", {31'd0, busy}, 32'd0);
    toEdge(cyc + 1);

    // Pointer wrap: 12-byte stream with valid held high
    base = start_times.size();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(8'h10 + 8'(i), tmp);
    end
    drain(700);
    checkSpacing("wrap", base, 12);
    checkOutput("final_queue", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
